// File: rtl/reg_axil_pkg.sv
// reg_axil_pkg: shared FSM states and AXI response constants for the command master.
package reg_axil_pkg;
    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, RSP} state_e;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_DEAD;
endpackage

// File: rtl/reg_axil_timeout_cnt.sv
// reg_axil_timeout_cnt: saturating transaction watchdog; expired_o stays high once LIMIT is reached.
module reg_axil_timeout_cnt #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt_q;
    assign expired_o = cnt_q == W'(LIMIT);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else if (clear_i) cnt_q <= '0;
        else if (enable_i && !expired_o) cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: rtl/reg_axil_cmd_master.sv
// reg_axil_cmd_master: single-outstanding AXI4-Lite master driven by a valid/ready command stream.
// Optional watchdog abort is compiled in with REG_AXIL_CMD_TIMEOUT_EN.
module reg_axil_cmd_master
    import reg_axil_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);
    state_e state_q, state_d;
    logic aw_q, aw_d, w_q, w_d, ar_q, ar_d, b_q, b_d, r_q, r_d, rv_q, rv_d, to_q, to_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0] wstrb_q, wstrb_d;
    logic [1:0] resp_q, resp_d;
    logic busy, expired;

    assign busy = state_q inside {WR, WR_B, RD_A, RD_R};

`ifdef REG_AXIL_CMD_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
    reg_axil_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk_i    (aclk),
        .rst_i    (areset),
        .clear_i  (cmd_valid && cmd_ready),
        .enable_i (busy),
        .expired_o(expired)
    );
`else
    localparam logic TO_EN = 1'b0;
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES == 0;
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        aw_d = aw_q;
        w_d = w_q;
        ar_d = ar_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        resp_d = resp_q;
        to_d = to_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                state_d = cmd_write ? WR : RD_A;
                addr_d = cmd_addr;
                wdata_d = cmd_wdata;
                wstrb_d = cmd_wstrb;
                aw_d = cmd_write;
                w_d = cmd_write;
                ar_d = !cmd_write;
            end
            WR: begin
                aw_d = aw_q && !m_axi_awready;
                w_d = w_q && !m_axi_wready;
                state_d = (aw_d || w_d) ? WR : WR_B;
            end
            WR_B: if (m_axi_bvalid) begin
                state_d = RSP;
                rdata_d = '0;
                resp_d = m_axi_bresp;
                to_d = 1'b0;
            end
            RD_A: if (m_axi_arready) begin
                state_d = RD_R;
                ar_d = 1'b0;
            end
            RD_R: if (m_axi_rvalid) begin
                state_d = RSP;
                rdata_d = m_axi_rdata;
                resp_d = m_axi_rresp;
                to_d = 1'b0;
            end
            RSP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A watchdog hit overrides any handshake landing in the same cycle.
        if (expired && busy) begin
            state_d = RSP;
            aw_d = 1'b0;
            w_d = 1'b0;
            ar_d = 1'b0;
            rdata_d = TIMEOUT_RDATA;
            resp_d = RESP_SLVERR;
            to_d = 1'b1;
        end
        b_d = state_d == WR_B || (TO_EN && state_d == IDLE);
        r_d = state_d == RD_R || (TO_EN && state_d == IDLE);
        rv_d = state_d == RSP;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            aw_q <= 1'b0;
            w_q <= 1'b0;
            ar_q <= 1'b0;
            b_q <= 1'b0;
            r_q <= 1'b0;
            rv_q <= 1'b0;
            to_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            resp_q <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            aw_q <= aw_d;
            w_q <= w_d;
            ar_q <= ar_d;
            b_q <= b_d;
            r_q <= r_d;
            rv_q <= rv_d;
            to_q <= to_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            resp_q <= resp_d;
        end
    end

    assign cmd_ready = state_q == IDLE;
    assign rsp_valid = rv_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp = resp_q;
    assign rsp_timeout = to_q;
    assign m_axi_awaddr = addr_q;
    assign m_axi_awprot = 3'b000;
    assign m_axi_awvalid = aw_q;
    assign m_axi_wdata = wdata_q;
    assign m_axi_wstrb = wstrb_q;
    assign m_axi_wvalid = w_q;
    assign m_axi_bready = b_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_arprot = 3'b000;
    assign m_axi_arvalid = ar_q;
    assign m_axi_rready = r_q;
endmodule

// File: doc/reg_axil_cmd_master.md
# reg_axil_cmd_master

- Single-outstanding AXI4-Lite master that turns a simple valid/ready command stream into AXI4-Lite register transactions.
- Sits directly upstream of the register slave top level: its `m_axi_*` outputs drive that block's `m_axi_*` inputs.
- Used by host-side control logic (test sequencers, init engines) to reach the IO_TEST register array.
- Each command yields exactly one response on a valid/ready response stream carrying read data and AXI status.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: cycles allowed from command accept to AXI completion; used only when the timeout feature is compiled in.
- `ADDR_W`, default 32: address width; passed straight through to AW/AR.

Clocking and reset: one clock; reset is asynchronous and active-high.

Ports:
- `aclk`  in  1  single clock; all logic is rising-edge.
- `areset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W  byte address.
- `cmd_wdata`  in  32  write data.
- `cmd_wstrb`  in  4  write byte strobes.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  32  read data; 0 for writes.
- `rsp_resp`  out  2  AXI BRESP/RRESP, or SLVERR on timeout.
- `rsp_timeout`  out  1  response was produced by timeout.
- AXI4-Lite master port, widths per AXI4-Lite:
  - Write address: `m_axi_awaddr`, `m_axi_awprot`, `m_axi_awvalid` (out); `m_axi_awready` (in).
  - Write data: `m_axi_wdata`, `m_axi_wstrb`, `m_axi_wvalid` (out); `m_axi_wready` (in).
  - Write response: `m_axi_bresp`, `m_axi_bvalid` (in); `m_axi_bready` (out).
  - Read address: `m_axi_araddr`, `m_axi_arprot`, `m_axi_arvalid` (out); `m_axi_arready` (in).
  - Read data: `m_axi_rdata`, `m_axi_rresp`, `m_axi_rvalid` (in); `m_axi_rready` (out).

## Operation
- States: IDLE, WR, WR_B, RD_A, RD_R, RSP.
- IDLE:
  - `cmd_ready`=1.
  - On a command handshake, latch addr/wdata/wstrb and go to WR or RD_A.
- WR:
  - `awvalid` and `wvalid` assert together.
  - Each channel drops independently on its own handshake.
  - Go to WR_B when both channels are done; this includes both completing in the same cycle.
- WR_B: `bready`=1; on `bvalid`, capture `bresp`, set `rsp_rdata`=0, go to RSP.
- RD_A: `arvalid`=1; on `arready`, go to RD_R.
- RD_R: `rready`=1; on `rvalid`, capture `rdata`/`rresp`, go to RSP.
- RSP: `rsp_valid`=1; outputs are held stable until `rsp_ready`, then return to IDLE.
- `awprot`/`arprot` are always 3'b000.
- All AXI outputs and `rsp_*` are driven from flops; there are no combinational in-to-out paths.
- `cmd_ready` is decoded from state only.
- Non-OKAY `bresp`/`rresp` values pass through unmodified, with `rsp_timeout`=0.
- Reset (any cycle, including mid-transaction):
  - State returns to IDLE; every valid/ready output goes to 0.
  - `rsp_rdata`=0, `rsp_resp`=0, `rsp_timeout`=0, address/data outputs=0.
  - An in-flight AXI transaction is abandoned; the slave shares the same reset.

## Timing
- Zero-wait slave, write:
  - Cycle 0: command handshake.
  - Cycle 1: AW and W handshakes.
  - Cycle 2: B handshake.
  - Cycle 3: `rsp_valid`.
- Zero-wait slave, read:
  - Cycle 0: command handshake.
  - Cycle 1: AR handshake.
  - Cycle 2: R handshake.
  - Cycle 3: `rsp_valid`.
- Peak throughput is one command per 4 cycles when `rsp_ready` is held high.
- `cmd_ready` rises the cycle after the `rsp_valid`/`rsp_ready` handshake.
- Any number of slave wait states is tolerated; valids are never withdrawn before their handshake, except on timeout.

## Configuration
- Macro `REG_AXIL_CMD_TIMEOUT_EN`, defined:
  - A counter clears on command accept and increments every cycle in WR, WR_B, RD_A and RD_R.
  - When the counter reaches `TIMEOUT_CYCLES`, drop all AXI valids and go to RSP with `rsp_resp`=2'b10, `rsp_rdata`=32'hDEAD_DEAD, `rsp_timeout`=1.
  - While in IDLE, `bready` and `rready` stay high so a late response from the abandoned transaction is sunk.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Macro undefined: no counter; the block waits forever; `rsp_timeout` is tied to 0; `bready`/`rready` are low in IDLE.

## Structure
- Package `reg_axil_pkg` holds:
  - State enum.
  - Response constants: RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - TIMEOUT_RDATA=32'hDEAD_DEAD.
- Optional sub-module `reg_axil_timeout_cnt` (clear, enable, expired), instantiated only under `REG_AXIL_CMD_TIMEOUT_EN`.
- Everything else is one FSM module.

## Test plan
- Write to 0x0000_0000 with data 0x1234_5678 and wstrb 0xF, zero-wait slave -> AW and W handshakes at cycle 1, `rsp_valid` at cycle 3 with `rsp_resp`=0 and `rsp_rdata`=0; IO_TEST0_VALUE reads back 0x1234_5678.
- Read of 0x0000_000C with IO_TEST3_VALUE=0xA5A5_0001 -> `rsp_rdata`=0xA5A5_0001, `rsp_resp`=0, `rsp_valid` at cycle 3.
- `awready` delayed 3 cycles while `wready` is immediate -> `wvalid` drops after 1 cycle, `awvalid` holds 4 cycles, single B handshake, response correct.
- `rsp_ready` held low for 5 cycles -> `rsp_*` stable, `cmd_ready`=0 throughout; the next command is accepted the cycle after the handshake.
- With `REG_AXIL_CMD_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, slave never asserts `arready` -> after 16 cycles `arvalid`=0 and the response is SLVERR / 0xDEAD_DEAD / `rsp_timeout`=1.
- `areset` pulsed during WR_B -> all outputs at reset values the same cycle; the following write completes normally.
